// File: rtl/pll_lock_supervisor.sv
// Supervises an iCE40 PLL from the oscillator domain: pulses RESETB, waits for a stable LOCK,
// then holds ready/sys_reset; retries on timeout and filters LOCK glitches while running.
module pll_lock_supervisor #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1200,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned DROP_FILTER   = 4,
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   clear_counts,
  output logic                   pll_resetb,
  output logic                   sys_reset,
  output logic                   ready,
  output logic                   lost_lock,
  output logic [COUNT_WIDTH-1:0] retry_count,
  output logic [COUNT_WIDTH-1:0] loss_count
);

  localparam int unsigned MaxA = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB = (STABLE_CYCLES > DROP_FILTER) ? STABLE_CYCLES : DROP_FILTER;
  localparam int unsigned MaxCycles = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned TW = $clog2(MaxCycles + 1);

  localparam logic [TW-1:0] ResetLast   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] StableLast  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] DropLast    = TW'(DROP_FILTER - 1);

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  localparam logic [1:0] StPllReset  = 2'd0;
  localparam logic [1:0] StWaitLock  = 2'd1;
  localparam logic [1:0] StStabilize = 2'd2;
  localparam logic [1:0] StRun       = 2'd3;

  logic [1:0]             sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] retry_q, retry_d;
  logic [COUNT_WIDTH-1:0] loss_q, loss_d;
  logic                   lost_q;
  logic                   retry_inc, loss_det;

  assign locked_s = sync_q[1];

  // One timer serves every state: reset pulse length, lock timeout, stable run, drop run.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_inc = 1'b0;
    loss_det  = 1'b0;
    case (state_q)
      StPllReset: begin
        if (timer_q == ResetLast) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStabilize;
          timer_d = '0;
        end else if (timer_q == TimeoutLast) begin
          state_d   = StPllReset;
          timer_d   = '0;
          retry_inc = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StStabilize: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StRun: begin
        if (locked_s) begin
          timer_d = '0;
        end else if (timer_q == DropLast) begin
          state_d  = StPllReset;
          timer_d  = '0;
          loss_det = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = StPllReset;
        timer_d = '0;
      end
    endcase
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    retry_d = retry_q;
    loss_d  = loss_q;
    if (clear_counts) begin
      retry_d = '0;
      loss_d  = '0;
    end else begin
      if (retry_inc && (retry_q != CountMax)) retry_d = retry_q + COUNT_WIDTH'(1);
      if (loss_det && (loss_q != CountMax))   loss_d  = loss_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= StPllReset;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], locked};
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
      lost_q  <= loss_det;
    end
  end

  assign pll_resetb  = (state_q != StPllReset);
  assign ready       = (state_q == StRun);
  assign sys_reset   = ~ready;
  assign lost_lock   = lost_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized bench for pll_lock_supervisor, checked against a phase/run-length model of the
// supervisor's rules plus explicit timing checks derived from those rules.
module tb_pll_lock_supervisor;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int DF = 3;
  localparam int CW = 3;
  localparam int CMax = (1 << CW) - 1;

  localparam int PhReset = 0;
  localparam int PhWait  = 1;
  localparam int PhStab  = 2;
  localparam int PhRun   = 3;

  localparam logic [9:0] ResetVec = 10'b0010_000_000;

  logic          clock;
  logic          reset;
  logic          locked;
  logic          clear_counts;
  logic          pll_resetb;
  logic          sys_reset;
  logic          ready;
  logic          lost_lock;
  logic [CW-1:0] retry_count;
  logic [CW-1:0] loss_count;

  int n_cmp;
  int n_fail;

  pll_lock_supervisor #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .DROP_FILTER  (DF),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .locked      (locked),
    .clear_counts(clear_counts),
    .pll_resetb  (pll_resetb),
    .sys_reset   (sys_reset),
    .ready       (ready),
    .lost_lock   (lost_lock),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: phase plus time-in-phase, global run length of low lock samples.
  int m_phase = PhReset;
  int m_age   = 0;
  int m_lo    = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_lost  = 1'b0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;
  bit m_ls;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = PhReset;
      m_age   = 0;
      m_lo    = 0;
      m_retry = 0;
      m_loss  = 0;
      m_lost  = 1'b0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
    end else begin
      m_ls   = m_s2;
      m_lo   = m_ls ? 0 : m_lo + 1;
      m_age  = m_age + 1;
      m_lost = 1'b0;
      case (m_phase)
        PhReset: if (m_age == RC) begin m_phase = PhWait; m_age = 0; end
        PhWait: begin
          if (m_ls) begin
            m_phase = PhStab; m_age = 0;
          end else if (m_age == LT) begin
            m_phase = PhReset; m_age = 0;
            if (m_retry < CMax) m_retry = m_retry + 1;
          end
        end
        PhStab: begin
          if (!m_ls) begin m_phase = PhWait; m_age = 0; end
          else if (m_age == SC) begin m_phase = PhRun; m_age = 0; end
        end
        default: begin
          if (m_lo == DF) begin
            m_phase = PhReset; m_age = 0; m_lost = 1'b1;
            if (m_loss < CMax) m_loss = m_loss + 1;
          end
        end
      endcase
      if (clear_counts) begin m_retry = 0; m_loss = 0; end
      m_s2 = m_s1;
      m_s1 = locked;
    end
  end

  function automatic logic [9:0] dut_vec();
    return {pll_resetb, ready, sys_reset, lost_lock, retry_count, loss_count};
  endfunction

  function automatic logic [9:0] mdl_vec();
    logic [CW-1:0] r, l;
    r = m_retry[CW-1:0];
    l = m_loss[CW-1:0];
    return {m_phase != PhReset, m_phase == PhRun, m_phase != PhRun, m_lost, r, l};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clear_counts = 1'b0;
    locked = 1'($urandom_range(0, 1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== ResetVec) begin
        n_fail++;
        $display("FAIL reset c=%0d: got %b want %b", c, dut_vec(), ResetVec);
      end
    end
    locked = 1'b0;
  endtask

  // Entered with reset held high and locked low; releases reset and brings the PLL up.
  task automatic test_bringup(input int dly);
    int low_cnt, hi_cnt, since_hi, ready_at;
    low_cnt  = pll_resetb ? 0 : 1;
    hi_cnt   = 0;
    since_hi = -1;
    ready_at = -1;
    reset    = 1'b0;
    for (int c = 0; c < 30 + dly; c++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL bringup c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (!pll_resetb) low_cnt++;
      else hi_cnt++;
      if (since_hi >= 0) since_hi++;
      if (ready && ready_at < 0 && since_hi >= 0) ready_at = since_hi;
      if (hi_cnt == dly && since_hi < 0) begin
        locked = 1'b1;
        since_hi = 0;
      end
    end
    n_cmp++;
    if (low_cnt != RC) begin
      n_fail++;
      $display("FAIL bringup_reset_len: got %0d want %0d", low_cnt, RC);
    end
    n_cmp++;
    if (ready_at != 3 + SC) begin
      n_fail++;
      $display("FAIL bringup_ready_edge: got %0d want %0d", ready_at, 3 + SC);
    end
  endtask

  task automatic test_glitch();
    int short_len, long_len, dly, pulses, low_cnt, prb_hi;
    bit relock;
    short_len = $urandom_range(1, DF - 1);
    for (int c = 0; c < short_len + 6; c++) begin
      locked = (c >= short_len);
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL glitch_short c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      n_cmp++;
      if (ready !== 1'b1 || lost_lock !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_ignored c=%0d: ready=%b lost=%b want 1 0", c, ready, lost_lock);
      end
    end
    long_len = $urandom_range(DF, DF + 2);
    dly      = $urandom_range(1, 6);
    pulses   = 0;
    low_cnt  = 0;
    prb_hi   = 0;
    relock   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      locked = (c >= long_len) && relock && (prb_hi >= dly);
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL glitch_long c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (lost_lock) pulses++;
      if (!pll_resetb) begin low_cnt++; relock = 1'b1; prb_hi = 0; end
      else prb_hi++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if (low_cnt != RC) begin
      n_fail++;
      $display("FAIL glitch_reset_len: got %0d want %0d", low_cnt, RC);
    end
    n_cmp++;
    if (ready !== 1'b1 || loss_count !== 3'd1) begin
      n_fail++;
      $display("FAIL glitch_relock: ready=%b loss=%0d want 1 1", ready, loss_count);
    end
  endtask

  // Loses lock, re-locks, then a single low sample interrupts STABILIZE after h-1 highs.
  task automatic test_unstable();
    int h, dly, k, ready_at, prb_hi;
    bit relock;
    h        = $urandom_range(2, SC);
    dly      = $urandom_range(1, 6);
    k        = -1;
    ready_at = -1;
    prb_hi   = 0;
    relock   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (k < 0 && relock && prb_hi >= dly) k = 0;
      locked = (k >= 0) && (k != h);
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL unstable c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (k >= 0) k++;
      if (ready && ready_at < 0 && k >= 0) ready_at = k;
      if (!pll_resetb) begin relock = 1'b1; prb_hi = 0; end
      else prb_hi++;
    end
    n_cmp++;
    if (ready_at != 3 + SC + h + 1) begin
      n_fail++;
      $display("FAIL unstable_ready_edge h=%0d: got %0d want %0d", h, ready_at, 4 + SC + h);
    end
    n_cmp++;
    if (retry_count !== 3'd0 || loss_count !== 3'd2) begin
      n_fail++;
      $display("FAIL unstable_counts: retry=%0d loss=%0d want 0 2", retry_count, loss_count);
    end
  endtask

  task automatic test_mid_run();
    reset  = 1'b1;
    locked = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (dut_vec() !== ResetVec) begin
      n_fail++;
      $display("FAIL midrun_reset: got %b want %b", dut_vec(), ResetVec);
    end
    test_bringup($urandom_range(1, 6));
  endtask

  task automatic test_timeout();
    int last_rise;
    logic prev_prb;
    locked    = 1'b0;
    last_rise = -1;
    prev_prb  = 1'b1;
    for (int c = 0; c < DF + 2 + RC + (RC + LT) * 9; c++) begin
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL timeout c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (pll_resetb && !prev_prb) begin
        if (last_rise >= 0) begin
          n_cmp++;
          if (c - last_rise != RC + LT) begin
            n_fail++;
            $display("FAIL timeout_period: got %0d want %0d", c - last_rise, RC + LT);
          end
        end
        last_rise = c;
      end
      prev_prb = pll_resetb;
    end
    n_cmp++;
    if (retry_count !== 3'd7 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_saturate: retry=%0d ready=%b want 7 0", retry_count, ready);
    end
  endtask

  task automatic test_clear();
    int dly, prb_hi, pulses, c;
    dly    = $urandom_range(1, 6);
    prb_hi = 0;
    c      = 0;
    while (!ready && c < 200) begin
      locked = (prb_hi >= dly);
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL clear_relock c=%0d: got %b want %b", c, dut_vec(), mdl_vec());
      end
      if (!pll_resetb) prb_hi = 0;
      else prb_hi++;
      c++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_reach_run: ready=%b want 1", ready);
    end
    pulses = 0;
    for (int i = 0; i < DF + 6; i++) begin
      locked = 1'b0;
      // The loss is detected on the edge that samples the DF-th low after the synchronizer.
      clear_counts = (i == DF + 1);
      @(negedge clock);
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        $display("FAIL clear_drop i=%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
      if (lost_lock) pulses++;
    end
    clear_counts = 1'b0;
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL clear_pulse: got %0d want 1", pulses);
    end
    n_cmp++;
    if (retry_count !== 3'd0 || loss_count !== 3'd0) begin
      n_fail++;
      $display("FAIL clear_priority: retry=%0d loss=%0d want 0 0", retry_count, loss_count);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    locked       = 1'b0;
    clear_counts = 1'b0;
    test_reset();
    test_bringup(5);
    test_glitch();
    test_unstable();
    test_mid_run();
    test_timeout();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Control-side companion to the iCE40 PLL wrapper. It runs on the raw board oscillator clock and drives the PLL's RESETB. It consumes the PLL's LOCK output and derives a clean system reset and ready flag for the PLL clock domain. It also retries lock acquisition on timeout, filters LOCK glitches, and counts retries and lock losses for debug readout.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low per PLL reset pulse (min 1)
LOCK_TIMEOUT, 1200, cycles to wait for LOCK before re-resetting the PLL (100 us at 12 MHz)
STABLE_CYCLES, 256, consecutive synchronized LOCK-high samples required before ready
DROP_FILTER, 4, consecutive LOCK-low samples in RUN that constitute a loss of lock (min 1)
COUNT_WIDTH, 8, width of retry_count and loss_count

Ports:
clock  input  1  oscillator clock, free-running, independent of PLL
reset  input  1  synchronous, active-high
locked  input  1  PLL LOCK, asynchronous to clock
clear_counts  input  1  synchronous clear of retry_count and loss_count
pll_resetb  output  1  to PLL RESETB, active-low
sys_reset  output  1  active-high reset request to PLL-domain logic (consumer re-synchronizes)
ready  output  1  PLL locked and stable
lost_lock  output  1  one-cycle pulse on detected loss of lock in RUN
retry_count  output  COUNT_WIDTH  saturating count of lock timeouts
loss_count  output  COUNT_WIDTH  saturating count of lock losses

Behaviour:
- Interface: one clock, named clock. Reset is synchronous and active-high, named reset. No other clock or reset.
- locked passes through a 2-flop synchronizer; locked_s is the second flop. All decisions use locked_s only.
- All outputs are registered or decoded from the state register. No combinational path exists from any input to any output.
- Reset values: state PLL_RESET, timers 0, synchronizer 0, pll_resetb=0, sys_reset=1, ready=0, lost_lock=0, both counts 0.
- Reset asserted mid-operation: the next edge restores the reset values, regardless of state. pll_resetb goes low immediately.
- PLL_RESET: pll_resetb=0.
  - The timer counts cycles in the state.
  - After exactly RESET_CYCLES cycles, go to WAIT_LOCK. pll_resetb is therefore low for RESET_CYCLES cycles.
- WAIT_LOCK: pll_resetb=1. The timer counts from 0.
  - locked_s=1 -> STABILIZE, timer cleared.
  - Timer reaches LOCK_TIMEOUT-1 with locked_s=0 -> PLL_RESET and retry_count+1.
  - If lock and timeout coincide, lock wins.
- STABILIZE: pll_resetb=1. The timer counts consecutive locked_s=1 samples.
  - Any locked_s=0 -> WAIT_LOCK with a fresh timeout. There is no retry increment.
  - After STABLE_CYCLES consecutive highs -> RUN.
- RUN: ready=1, sys_reset=0, pll_resetb=1.
  - The drop counter counts consecutive locked_s=0 samples. It clears on any high sample, so shorter glitches are ignored.
  - When the drop counter reaches DROP_FILTER: lost_lock=1 for one cycle, loss_count+1, go to PLL_RESET.
  - ready=0 and sys_reset=1 in the same cycle as the lost_lock pulse.
- sys_reset = NOT ready in all states.
- Counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- clear_counts zeroes both counts on the next edge. clear_counts beats a simultaneous increment.
- Timer widths are derived from $clog2 of the largest parameter. There must be no overflow at the maximum parameter value.

Test Plan:
(All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, DROP_FILTER=3, COUNT_WIDTH=3.)
1. Bring-up.
   - Stimulus: release reset; raise locked 5 cycles after pll_resetb rises and keep it high.
   - Response: pll_resetb low for exactly 4 cycles after reset release. ready and sys_reset flip together exactly 11 edges (2 sync + 1 + 8) after the first edge that samples locked high. lost_lock stays 0; counts stay 0.
2. Timeout and saturation.
   - Stimulus: hold locked=0.
   - Response: pll_resetb has a period of 24 cycles (4 low, 20 high). retry_count goes 1,2,...,7 and then stays 7. ready stays 0.
3. Glitch filter.
   - Stimulus: in RUN, drop locked for 2 cycles.
   - Response: no change.
   - Stimulus: then drop locked for 3 cycles.
   - Response: one lost_lock pulse; loss_count=1; ready=0; pll_resetb low for 4 cycles; re-lock follows scenario 1 timing.
4. Unstable lock.
   - Stimulus: in STABILIZE, drop locked_s for 1 cycle after 5 highs.
   - Response: return to WAIT_LOCK; retry_count unchanged; ready never asserts; eventual stable lock reaches RUN normally.
5. Clear priority.
   - Stimulus: assert clear_counts in the same cycle as a loss detection.
   - Response: loss_count=0 and retry_count=0 afterwards; lost_lock still pulses.
6. Reset mid-RUN.
   - Stimulus: assert reset for 1 cycle while in RUN.
   - Response: next cycle pll_resetb=0, sys_reset=1, ready=0, counts 0. The full bring-up then repeats.
